// File: rtl/j_insfetch_pkg.sv
// Shared types and widths for the Jerry instruction prefetch controller.
package j_insfetch_pkg;

    localparam int INSW  = 16;
    localparam int LONGW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/j_insq.sv
// Instruction word FIFO: up to two pushes and one pop per cycle, synchronous flush, free-slot count.
module j_insq
    import j_insfetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [1:0]      push_n,
    input  logic [INSW-1:0] push_w0,
    input  logic [INSW-1:0] push_w1,
    input  logic            pop,
    output logic [INSW-1:0] head,
    output logic            empty,
    output logic [CW-1:0]   free
);

    logic [INSW-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];
    assign empty  = (count == '0);
    assign free   = CW'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= wr_ptr + PW'(push_n);
            count  <= count + CW'(push_n) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing is visible until count covers it.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (push_n != 2'd0) mem[wr_ptr] <= push_w0;
            if (push_n == 2'd2) mem[wr_ptr + 1'b1] <= push_w1;
        end
    end

endmodule

// File: rtl/j_insfetch.sv
// Jerry instruction prefetch: long fetches split into 16-bit words, queued for the execution controller.
// Optional JINSFETCH_BYPASS_EN presents the first half of an ack straight from ifdata when the queue is empty.
module j_insfetch
    import j_insfetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             go,
    input  logic             pcld,
    input  logic [AW-1:0]    pcdata,
    input  logic             romold,
    output logic             ifreq,
    output logic [AW-1:0]    ifaddr,
    input  logic             ifack,
    input  logic [LONGW-1:0] ifdata,
    output logic             insrdy,
    output logic [INSW-1:0]  instr,
    output logic [AW-1:0]    pc_out,
    output fetch_state_t     dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef JINSFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Handshake: ifreq rises with ifaddr valid and both hold until the single-cycle ifack;
    // a word moves to the consumer on any edge where insrdy & romold are both high.
    fetch_state_t    state, state_next;
    logic [AW-1:0]   fetch_ptr, fetch_ptr_next;
    logic [AW-1:0]   ifaddr_q;
    logic [AW-1:0]   pc_q;
    logic            skip_hi;

    logic            q_empty;
    logic [INSW-1:0] q_head;
    logic [CW-1:0]   q_free;
    logic [1:0]      push_n;
    logic [INSW-1:0] push_w0, push_w1;
    logic            q_pop;

    logic            ack_take, byp_valid, pop_fire, issue;
    logic [INSW-1:0] first_half;
    logic [CW-1:0]   free_after;

    always_comb begin
        ack_take   = (state == FETCH) && ifack && !pcld;
        first_half = skip_hi ? ifdata[15:0] : ifdata[31:16];
        byp_valid  = BYPASS && q_empty && ack_take;
        insrdy     = !q_empty || byp_valid;
        instr      = !q_empty ? q_head : (byp_valid ? first_half : '0);
        pop_fire   = romold && insrdy && !pcld;
        q_pop      = pop_fire && !q_empty;

        push_n  = 2'd0;
        push_w0 = ifdata[31:16];
        push_w1 = ifdata[15:0];
        if (ack_take) begin
            if (skip_hi) begin
                push_n  = 2'd1;
                push_w0 = ifdata[15:0];
            end else begin
                push_n = 2'd2;
            end
            // A pop against an empty queue can only be the bypassed half.
            if (pop_fire && q_empty) begin
                push_n  = push_n - 2'd1;
                push_w0 = ifdata[15:0];
            end
        end
        free_after = q_free + CW'(q_pop) - CW'(push_n);

        fetch_ptr_next = fetch_ptr;
        if (pcld)          fetch_ptr_next = {pcdata[AW-1:2], 2'b00};
        else if (ack_take) fetch_ptr_next = fetch_ptr + AW'(4);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go && !pcld && free_after >= CW'(2)) state_next = FETCH;
            end
            FETCH: begin
                if (ifack) begin
                    if (!pcld && go && free_after >= CW'(2)) state_next = FETCH;
                    else                                     state_next = IDLE;
                end else if (pcld) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (ifack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        issue = (state_next == FETCH) && ((state == IDLE) || ack_take);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_ptr <= '0;
            ifaddr_q  <= '0;
            skip_hi   <= 1'b0;
            pc_q      <= '0;
        end else begin
            state     <= state_next;
            fetch_ptr <= fetch_ptr_next;
            if (issue) ifaddr_q <= fetch_ptr_next;
            if (pcld) begin
                skip_hi <= pcdata[1];
                pc_q    <= {pcdata[AW-1:1], 1'b0};
            end else begin
                if (ack_take) skip_hi <= 1'b0;
                if (pop_fire) pc_q <= pc_q + AW'(2);
            end
        end
    end

    assign ifreq     = (state != IDLE);
    assign ifaddr    = ifaddr_q;
    assign pc_out    = pc_q;
    assign dbg_state = state;

    j_insq #(.DEPTH(DEPTH)) u_insq (
        .clk     (sys_clk),
        .reset   (reset),
        .flush   (pcld),
        .push_n  (push_n),
        .push_w0 (push_w0),
        .push_w1 (push_w1),
        .pop     (q_pop),
        .head    (q_head),
        .empty   (q_empty),
        .free    (q_free)
    );

endmodule

// File: tb/tb_j_insfetch.sv
// Bench for j_insfetch: directed fetch/jump/full/reset cases plus random traffic against a word-stream model.
module tb_j_insfetch;
    import j_insfetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 24;

    logic             sys_clk = 1'b0;
    logic             reset, go, pcld, romold, ifack;
    logic [AW-1:0]    pcdata;
    logic [LONGW-1:0] ifdata;
    logic             ifreq, insrdy;
    logic [AW-1:0]    ifaddr, pc_out;
    logic [INSW-1:0]  instr;
    fetch_state_t     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_mode = 0;
    logic ack_phase = 1'b0;

    // Model: expected word stream as {pc, word}, plus where the next kept fetch must come from.
    logic [AW+INSW-1:0] exp_q[$];
    logic [AW-1:0]      m_ptr = '0;
    logic               m_skip = 1'b0;
    logic               m_discard = 1'b0;
    logic               prev_req = 1'b0;
    logic               prev_ack = 1'b0;
    logic [AW-1:0]      prev_addr = '0;

    j_insfetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .go        (go),
        .pcld      (pcld),
        .pcdata    (pcdata),
        .romold    (romold),
        .ifreq     (ifreq),
        .ifaddr    (ifaddr),
        .ifack     (ifack),
        .ifdata    (ifdata),
        .insrdy    (insrdy),
        .instr     (instr),
        .pc_out    (pc_out),
        .dbg_state (dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Advance one edge; inputs change 1 time unit after it. Bus responder lives here.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        pcld   = 1'b0;
        ifdata = $urandom;
        case (ack_mode)
            1:       ifack = ifreq && ($urandom_range(0, 2) == 0);
            2: begin
                ifack     = ifreq && ack_phase;
                ack_phase = ~ack_phase;
            end
            default: ifack = 1'b0;
        endcase
    endtask

    task automatic wait_ifreq();
        int n = 0;
        while (!ifreq && n < 20) begin
            tick();
            n++;
        end
        check("ifreq_timeout", ifreq, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; romold = 1'b0; ack_mode = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_ifreq",  ifreq,  0);
        check("rst_ifaddr", ifaddr, 0);
        check("rst_insrdy", insrdy, 0);
        check("rst_instr",  instr,  0);
        check("rst_pc_out", pc_out, 0);
        check("rst_state",  dbg_state, IDLE);
    endtask

    task automatic jump(input logic [AW-1:0] target);
        pcld   = 1'b1;
        pcdata = target;
    endtask

    // Monitor: samples mid-cycle, i.e. exactly what the next rising edge will act on.
    always @(negedge sys_clk) begin
        logic [AW+INSW-1:0] e;
        if (reset) begin
            exp_q.delete();
            m_ptr = '0; m_skip = 1'b0; m_discard = 1'b0;
            prev_req = 1'b0; prev_ack = 1'b0;
        end else begin
            check("insrdy_vs_model", insrdy, (exp_q.size() != 0));
            if (prev_req && !prev_ack) begin
                check("ifreq_held", ifreq, 1);
                check("ifaddr_stable", ifaddr, prev_addr);
            end
            if (insrdy && romold && !pcld) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_instr", instr, e[INSW-1:0]);
                    check("pop_pc", pc_out, e[AW+INSW-1:INSW]);
                end
            end
            if (ifreq && ifack) begin
                if (pcld || m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    check("ack_ifaddr", ifaddr, m_ptr);
                    if (!m_skip) exp_q.push_back({m_ptr, ifdata[31:16]});
                    exp_q.push_back({m_ptr + AW'(2), ifdata[15:0]});
                    check("no_overflow", (exp_q.size() <= DEPTH), 1);
                    m_ptr  = m_ptr + AW'(4);
                    m_skip = 1'b0;
                end
            end
            if (pcld) begin
                exp_q.delete();
                m_discard = m_discard || (ifreq && !ifack);
                m_ptr     = {pcdata[AW-1:2], 2'b00};
                m_skip    = pcdata[1];
            end
            prev_req  = ifreq;
            prev_ack  = ifack;
            prev_addr = ifaddr;
        end
    end

    initial begin
        reset = 1'b1; go = 1'b0; pcld = 1'b0; romold = 1'b0; ifack = 1'b0;
        pcdata = '0; ifdata = '0;
        do_reset();
        check_reset_vals();

        // Aligned jump, one long, two pops.
        go = 1'b1;
        jump(24'hF03000);
        tick();
        wait_ifreq();
        check("t1_ifaddr", ifaddr, 24'hF03000);
        ifack = 1'b1; ifdata = 32'h98761234; go = 1'b0;
        tick();
        check("t1_insrdy", insrdy, 1);
        check("t1_instr_hi", instr, 16'h9876);
        check("t1_pc_hi", pc_out, 24'hF03000);
        romold = 1'b1;
        tick();
        check("t1_instr_lo", instr, 16'h1234);
        check("t1_pc_lo", pc_out, 24'hF03002);
        tick();
        romold = 1'b0;
        check("t1_empty", insrdy, 0);

        // Jump to the low half of a long: high half skipped.
        go = 1'b1;
        jump(24'hF03006);
        tick();
        wait_ifreq();
        check("t2_ifaddr", ifaddr, 24'hF03004);
        ifack = 1'b1; ifdata = 32'hAAAA5555; go = 1'b0;
        tick();
        check("t2_instr", instr, 16'h5555);
        check("t2_pc", pc_out, 24'hF03006);
        romold = 1'b1;
        tick();
        romold = 1'b0;
        check("t2_empty", insrdy, 0);

        // Jump while a fetch is outstanding.
        go = 1'b1;
        jump(24'h000200);
        tick();
        wait_ifreq();
        tick();
        jump(24'h000401);
        tick();
        check("t3_held_req", ifreq, 1);
        check("t3_held_addr", ifaddr, 24'h000200);
        ifack = 1'b1; ifdata = 32'hDEADBEEF;
        tick();
        check("t3_dropped", insrdy, 0);
        wait_ifreq();
        check("t3_new_addr", ifaddr, 24'h000400);
        ifack = 1'b1; ifdata = 32'h11112222; go = 1'b0;
        tick();
        check("t3_instr", instr, 16'h1111);
        check("t3_pc", pc_out, 24'h000400);

        // Fill to DEPTH, then free slots one pop at a time.
        do_reset();
        go = 1'b1;
        jump(24'h000100);
        tick();
        wait_ifreq();
        ifack = 1'b1; ifdata = 32'h01010202;
        tick();
        wait_ifreq();
        ifack = 1'b1; ifdata = 32'h03030404;
        tick();
        check("t4_full_noreq", ifreq, 0);
        tick();
        check("t4_full_noreq2", ifreq, 0);
        romold = 1'b1;
        tick();
        romold = 1'b0;
        check("t4_one_free", ifreq, 0);
        tick();
        check("t4_one_free2", ifreq, 0);
        romold = 1'b1;
        tick();
        romold = 1'b0;
        check("t4_two_free", ifreq, 1);

        // Reset in the middle of a fetch, with an ack offered during reset.
        reset = 1'b1; ifack = 1'b1;
        tick();
        ifack = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0; go = 1'b0;
        tick();

        // Pop every cycle, ack every second cycle, across the address wrap.
        go = 1'b1;
        jump(24'hFFFFF8);
        ack_mode = 2;
        tick();
        for (int i = 0; i < 20 && !insrdy; i++) tick();
        check("t5_insrdy_start", insrdy, 1);
        romold = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("t5_insrdy_continuous", insrdy, 1);
        end
        romold = 1'b0;
        do_reset();

        // Random traffic.
        ack_mode = 1;
        for (int i = 0; i < 800; i++) begin
            tick();
            go     = ($urandom_range(0, 3) != 0);
            romold = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) jump(AW'($urandom));
        end
        go = 1'b0; ack_mode = 2; romold = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_insrdy", insrdy, 0);
        check("drain_ifreq", ifreq, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
